// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// apb_slave_regfile : APB slave register file with wait states, byte strobes,
//                     read-only hardware-sourced registers and PSLVERR.
// Revision: 1.0
// ============================================================================
module apb_slave_regfile #(
  parameter int                   ADDR_WIDTH  = 8,
  parameter int                   DATA_WIDTH  = 32,
  parameter int                   NUM_REGS    = 16,
  parameter int                   WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSELx,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in
);

  localparam int         c_nbytes  = DATA_WIDTH / 8;
  localparam int         c_lsb     = $clog2(c_nbytes);
  localparam int         c_idx_w   = ADDR_WIDTH - c_lsb;
  localparam logic [3:0] c_ws      = 4'(WAIT_STATES);
  localparam bit         c_zero_ws = (WAIT_STATES == 0);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [c_idx_w-1:0]      r_idx;
  logic                    r_write;
  logic                    r_err;
  logic [3:0]              r_cnt;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [DATA_WIDTH-1:0]   r_prdata;

  logic                    w_setup;
  logic [c_idx_w-1:0]      w_idx;
  logic                    w_range_err;
  logic                    w_misalign;
  logic                    w_ro;
  logic                    w_err;
  logic                    w_raise;
  logic [c_idx_w-1:0]      w_ld_idx;
  logic                    w_ld_write;
  logic                    w_ld_err;
  logic                    w_commit;
  logic [DATA_WIDTH-1:0]   w_rdval;
  logic [DATA_WIDTH-1:0]   w_rd [NUM_REGS];
  logic                    w_unused;

  assign w_setup     = (r_state == IDLE) && PSELx && !PENABLE;
  assign w_idx       = PADDR[ADDR_WIDTH-1:c_lsb];
  assign w_range_err = ({1'b0, w_idx} >= (c_idx_w+1)'(NUM_REGS));

  if (c_lsb > 0) begin : g_align
    assign w_misalign = |PADDR[c_lsb-1:0];
  end else begin : g_noalign
    assign w_misalign = 1'b0;
  end

  always_comb begin
    w_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == c_idx_w'(i)) w_ro = RO_MASK[i];
    end
  end

  assign w_err = w_range_err | w_misalign | (PWRITE & w_ro);

  // Zero-wait transfers complete at the setup edge, so take the live bus values.
  assign w_ld_idx   = w_setup ? w_idx  : r_idx;
  assign w_ld_write = w_setup ? PWRITE : r_write;
  assign w_ld_err   = w_setup ? w_err  : r_err;
  assign w_raise    = (w_setup && c_zero_ws) ||
                      ((r_state == ACCESS) && PSELx && !r_pready && (r_cnt == 4'd1));
  assign w_commit   = (r_state == ACCESS) && r_pready && PSELx && PENABLE &&
                      PWRITE && r_write && !r_err;

  always_comb begin
    w_rdval = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ld_idx == c_idx_w'(i)) w_rdval = w_rd[i];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_setup) w_next = ACCESS;
      ACCESS:  if (!PSELx || r_pready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      if (w_setup) begin
        r_idx   <= w_idx;
        r_write <= PWRITE;
        r_err   <= w_err;
        r_cnt   <= c_ws;
      end else if ((r_state == ACCESS) && PSELx && !r_pready && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_raise) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_ld_err;
        if (!w_ld_write) r_prdata <= w_ld_err ? '0 : w_rdval;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign w_rd[i] = hw_in[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_q;
      always_ff @(posedge PCLK) begin
        if (PRESET) begin
          r_q <= '0;
        end else if (w_commit && (r_idx == c_idx_w'(i))) begin
          for (int b = 0; b < c_nbytes; b++) begin
            if (PSTRB[b]) r_q[b*8 +: 8] <= PWDATA[b*8 +: 8];
          end
        end
      end
      assign w_rd[i] = r_q;
    end
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = w_rd[i];
  end

  // hw_in slices of read-write registers are intentionally ignored.
  assign w_unused = ^hw_in;

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// tb_apb_slave_regfile : directed self-checking bench, three instances
//                        (0/2/3 wait states) sharing one APB bus.
// Revision: 1.0
// ============================================================================
module tb_apb_slave_regfile;

  logic         clk;
  logic         preset;
  logic [2:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata0, prdata2, prdata3, prdata_m;
  logic         pready0, pready2, pready3, pready_m;
  logic         pslverr0, pslverr2, pslverr3, pslverr_m;
  logic [511:0] reg_out0, reg_out2, reg_out3;
  logic [511:0] hw_in0;
  logic [511:0] hw_zero;
  int           cur;
  int           vectors;
  int           miscompares;

  apb_slave_regfile #(.WAIT_STATES(0), .RO_MASK(16'h0004)) dut0 (
    .PCLK(clk), .PRESET(preset), .PSELx(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .reg_out(reg_out0), .hw_in(hw_in0));

  apb_slave_regfile #(.WAIT_STATES(2), .RO_MASK(16'h0000)) dut2 (
    .PCLK(clk), .PRESET(preset), .PSELx(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2),
    .reg_out(reg_out2), .hw_in(hw_zero));

  apb_slave_regfile #(.WAIT_STATES(3), .RO_MASK(16'h0000)) dut3 (
    .PCLK(clk), .PRESET(preset), .PSELx(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
    .reg_out(reg_out3), .hw_in(hw_zero));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    prdata_m = prdata0; pready_m = pready0; pslverr_m = pslverr0;
    case (cur)
      2: begin prdata_m = prdata2; pready_m = pready2; pslverr_m = pslverr2; end
      3: begin prdata_m = prdata3; pready_m = pready3; pslverr_m = pslverr3; end
      default: ;
    endcase
  end

  // One APB transfer; entered and left just after a rising edge.
  task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err,
                          output int waits, output int cycles, output logic [31:0] pre);
    cur = d;
    psel = '0;
    psel[(d == 0) ? 0 : (d == 2) ? 1 : 2] = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    pre = prdata_m;
    while (pready_m !== 1'b1 && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    cycles = waits + 2;
    rdata = prdata_m;
    err = pslverr_m;
    if (pready_m !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL xfer_timeout dut%0d addr=%h: PREADY=%b, required 1", d, addr, pready_m);
    end
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1; psel = '0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 preset = 1'b0;
    vectors++;
    if ({prdata0, pready0, pslverr0, prdata2, pready2, pslverr2, prdata3, pready3, pslverr3} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rd0=%h rdy0=%b err0=%b rd3=%h rdy3=%b, required all 0",
               prdata0, pready0, pslverr0, prdata3, pready3);
    end
    vectors++;
    if ({reg_out0, reg_out2, reg_out3} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: reg_out0=%h, required 0", reg_out0);
    end
  endtask

  task automatic test_read_all();
    logic [31:0] rd, pre;
    logic err;
    int w, c;
    for (int i = 0; i < 16; i++) begin
      apb_xfer(0, 1'b0, 8'(i * 4), 32'h0, 4'h0, rd, err, w, c, pre);
      vectors++;
      if (rd !== 32'h0 || err !== 1'b0 || w !== 0 || c !== 2) begin
        miscompares++;
        $display("FAIL read_all idx%0d: data=%h err=%b waits=%0d cycles=%0d, required 0/0/0/2",
                 i, rd, err, w, c);
      end
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd, pre;
    logic err;
    int w, c;
    apb_xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'b1111, rd, err, w, c, pre);
    apb_xfer(0, 1'b1, 8'h04, 32'h11223344, 4'b0101, rd, err, w, c, pre);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL strobe_write_err: PSLVERR=%b, required 0", err);
    end
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, w, c, pre);
    vectors++;
    if (rd !== 32'hDE22BE44 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL strobe_read: data=%h err=%b, required DE22BE44/0", rd, err);
    end
    vectors++;
    if (reg_out0[63:32] !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL strobe_reg_out: %h, required DE22BE44", reg_out0[63:32]);
    end
    apb_xfer(0, 1'b1, 8'h04, 32'hFFFFFFFF, 4'b0000, rd, err, w, c, pre);
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, w, c, pre);
    vectors++;
    if (rd !== 32'hDE22BE44 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_strobe: data=%h err=%b, required DE22BE44/0", rd, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, pre;
    logic err;
    int w1, c1, w2, c2;
    apb_xfer(0, 1'b1, 8'h0C, 32'hA5A5A5A5, 4'hF, rd, err, w1, c1, pre);
    apb_xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, rd, err, w2, c2, pre);
    vectors++;
    if (rd !== 32'hA5A5A5A5 || err !== 1'b0 || c1 !== 2 || c2 !== 2) begin
      miscompares++;
      $display("FAIL back_to_back: data=%h err=%b cycles=%0d/%0d, required A5A5A5A5/0/2/2",
               rd, err, c1, c2);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, pre;
    logic [511:0] exp;
    logic err;
    int w, c;
    hw_in0 = '0;
    hw_in0[64 +: 32] = 32'hCAFE0001;
    exp = '0;
    exp[32 +: 32] = 32'hDE22BE44;
    exp[64 +: 32] = 32'hCAFE0001;
    exp[96 +: 32] = 32'hA5A5A5A5;
    apb_xfer(0, 1'b1, 8'h40, 32'h12345678, 4'hF, rd, err, w, c, pre);
    vectors++;
    if (err !== 1'b1 || w !== 0) begin
      miscompares++;
      $display("FAIL err_range: PSLVERR=%b waits=%0d, required 1/0", err, w);
    end
    apb_xfer(0, 1'b1, 8'h05, 32'h12345678, 4'hF, rd, err, w, c, pre);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_misaligned: PSLVERR=%b, required 1", err);
    end
    apb_xfer(0, 1'b1, 8'h08, 32'h12345678, 4'hF, rd, err, w, c, pre);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_ro_write: PSLVERR=%b, required 1", err);
    end
    vectors++;
    if (reg_out0 !== exp) begin
      miscompares++;
      $display("FAIL err_no_change: reg_out0[127:0]=%h, required %h", reg_out0[127:0], exp[127:0]);
    end
    vectors++;
    if (prdata0 !== 32'hA5A5A5A5 || pslverr0 !== 1'b0) begin
      miscompares++;
      $display("FAIL prdata_hold: PRDATA=%h PSLVERR=%b, required A5A5A5A5/0", prdata0, pslverr0);
    end
    apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, err, w, c, pre);
    vectors++;
    if (rd !== 32'hCAFE0001 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL ro_read: data=%h err=%b, required CAFE0001/0", rd, err);
    end
    apb_xfer(0, 1'b0, 8'h42, 32'h0, 4'h0, rd, err, w, c, pre);
    vectors++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_read: data=%h err=%b, required 0/1", rd, err);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, pre;
    logic err;
    int w, c;
    apb_xfer(3, 1'b1, 8'h08, 32'h12345678, 4'hF, rd, err, w, c, pre);
    vectors++;
    if (w !== 3 || c !== 5 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_write: waits=%0d cycles=%0d err=%b, required 3/5/0", w, c, err);
    end
    apb_xfer(3, 1'b0, 8'h08, 32'h0, 4'h0, rd, err, w, c, pre);
    vectors++;
    if (rd !== 32'h12345678 || pre !== 32'h0 || w !== 3 || c !== 5 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_read: data=%h early=%h waits=%0d cycles=%0d err=%b, required 12345678/0/3/5/0",
               rd, pre, w, c, err);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, pre;
    logic [511:0] exp;
    logic err;
    int w, c;
    logic seen;
    cur = 2;
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04;
    pwdata = 32'h55; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    seen = pready2;
    @(posedge clk); #1 psel = '0; penable = 1'b0;
    seen = seen | pready2;
    @(posedge clk); #1;
    seen = seen | pready2 | pslverr2;
    vectors++;
    if (seen !== 1'b0 || reg_out2[63:32] !== 32'h0) begin
      miscompares++;
      $display("FAIL abort: PREADY/PSLVERR seen=%b reg1=%h, required 0/0", seen, reg_out2[63:32]);
    end
    apb_xfer(2, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, w, c, pre);
    vectors++;
    if (rd !== 32'h0 || err !== 1'b0 || w !== 2) begin
      miscompares++;
      $display("FAIL after_abort: data=%h err=%b waits=%0d, required 0/0/2", rd, err, w);
    end
    apb_xfer(2, 1'b1, 8'h00, 32'h99, 4'hF, rd, err, w, c, pre);
    apb_xfer(2, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, w, c, pre);
    vectors++;
    if (rd !== 32'h99 || prdata2 !== 32'h99) begin
      miscompares++;
      $display("FAIL pre_reset_read: data=%h, required 99", rd);
    end
    cur = 2;
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
    pwdata = 32'h77; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 preset = 1'b1;
    @(posedge clk); #1 preset = 1'b0; psel = '0; penable = 1'b0;
    @(posedge clk); #1;
    exp = '0;
    exp[64 +: 32] = 32'hCAFE0001;
    vectors++;
    if ({prdata2, pready2, pslverr2, prdata0} !== '0 || reg_out2 !== '0 || reg_out3 !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: rd2=%h rdy2=%b err2=%b reg_out2[63:0]=%h, required 0",
               prdata2, pready2, pslverr2, reg_out2[63:0]);
    end
    vectors++;
    if (reg_out0 !== exp) begin
      miscompares++;
      $display("FAIL mid_reset_dut0: reg_out0[127:0]=%h, required %h", reg_out0[127:0], exp[127:0]);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cur = 0;
    preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; hw_in0 = '0; hw_zero = '0;
    @(posedge clk); #1;
    test_reset();
    test_read_all();
    test_strobes();
    test_back_to_back();
    test_errors();
    test_wait_states();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- Parameterised APB (AMBA 3/4) slave register file; next-generation RTL slave behind the APB slave verification environment.
- Supports configurable data/address width, register count, wait-state insertion, byte strobes, read-only registers and PSLVERR signalling.
- Connects directly to the APB bus from the master. Exposes its register contents to core logic and takes hardware-driven values for read-only registers.

Parameters:
- ADDR_WIDTH, 8, PADDR width in bits (byte address).
- DATA_WIDTH, 32, PWDATA/PRDATA width. Must be 8, 16 or 32.
- NUM_REGS, 16, number of DATA_WIDTH-bit registers; 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 0, number of ACCESS cycles with PREADY=0 before completion; 0..15.
- RO_MASK, 0, NUM_REGS-bit mask. Bit i=1 makes register i read-only, sourced from hw_in.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSELx  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte lanes.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer complete, registered.
- PSLVERR  out  1  transfer error, registered; valid only while PREADY=1.
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH].
- hw_in  in  NUM_REGS*DATA_WIDTH  read values for RO registers; bits of RW registers are ignored.

Behaviour:
- Reset: when PRESET=1 at a PCLK edge:
  - state=IDLE; all RW registers=0.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - Wait counter=0; any in-flight transfer is aborted with no write.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when PSELx=1 & PENABLE=0 (setup sampled).
  - ACCESS -> IDLE on the edge where PREADY=1 is sampled with PSELx=1 & PENABLE=1.
  - ACCESS -> IDLE also if PSELx=0 is sampled (protocol abort). No write occurs, and PREADY/PSLVERR return to 0.
- Setup edge: latch the index (PADDR >> log2(DATA_WIDTH/8)), load the wait counter with WAIT_STATES, and compute the error flag.
- Error flag is set if any of the following holds:
  - index >= NUM_REGS;
  - PADDR low bits are not word-aligned;
  - PWRITE=1 and RO_MASK[index]=1.
- Completion timing: PREADY=1 during ACCESS cycle number WAIT_STATES+1 counted from the first PENABLE cycle.
  - WAIT_STATES=0: PREADY rises at the setup edge, so there are zero wait states.
  - Otherwise the counter decrements each ACCESS cycle and PREADY is set at the edge where the counter reaches 1.
  - PREADY is held high for exactly one cycle, then cleared.
- PSLVERR equals the error flag during the PREADY=1 cycle, and is 0 otherwise.
- Read data:
  - PRDATA is loaded on the same edge that raises PREADY.
  - RW register: stored value. RO register: hw_in slice sampled at that edge.
  - Error transfer: 0.
  - PRDATA holds its value until the next read completes; writes do not change it.
- Write commit: on the edge ending the completing cycle (PREADY=1, PSELx=1, PENABLE=1, PWRITE=1, no error).
  - Byte lane b is updated only where PSTRB[b]=1; PSTRB=0 leaves the register unchanged, which is legal and not an error.
  - The new value is visible on reg_out and to subsequent reads from the next cycle.
- Error writes never modify any register.
- Back-to-back transfers: a new setup sampled on the edge following completion is accepted. There is no idle-cycle requirement beyond the APB SETUP phase.
- PADDR, PWRITE, PWDATA and PSTRB are sampled only at the setup and commit edges. Changes during wait states are ignored except at the commit edge, where PWDATA/PSTRB are taken.
- reg_out for RO registers drives the hw_in slice.

Test Plan:
- Reset then read all: PRESET=1 for 2 cycles, then read idx 0..15 -> PRDATA=0x0000_0000, PSLVERR=0, PREADY high in first ACCESS cycle (WAIT_STATES=0).
- Write/read with strobes: write 0xDEADBEEF to 0x04 PSTRB=4'b1111, then write 0x11223344 PSTRB=4'b0101 -> read 0x04 returns 0xDE22BE44; reg_out[63:32]=0xDE22BE44.
- Wait states (WAIT_STATES=3): read 0x08 -> PREADY low for 3 ACCESS cycles and high in the 4th; PRDATA valid only then; transfer takes 5 PCLK cycles including SETUP.
- Errors: write to 0x40 (idx 16), write to 0x05 (misaligned), and write to RO idx 2 (RO_MASK=16'h0004, hw_in idx2=0xCAFE0001) -> PSLVERR=1 with PREADY, no register changes; read idx 2 returns 0xCAFE0001 with PSLVERR=0.
- Abort/reset mid-transfer (WAIT_STATES=2): PSELx dropped in 2nd ACCESS cycle of a write of 0x55 to idx 1 -> no write, PREADY stays 0, FSM IDLE. Repeat with PRESET=1 mid-access -> all outputs 0, registers 0.
- Back-to-back: write idx 3=0xA5A5A5A5 immediately followed by a read of idx 3 (no idle cycle) -> read returns 0xA5A5A5A5, each transfer 2 cycles.
